// File: rtl/rcpu_io_responder.sv
// rcpu_io_responder
//   IO-bus target for the RCPU SYS instruction. Decodes io_address and
//   services read/write strobes. It holds a TX byte FIFO that drains toward
//   the UART, an RX byte FIFO that the UART fills, an LED register and a
//   sticky tx_drop flag.
//
// Ports
//   clk, resetq                  clock, asynchronous active-low reset
//   io_read_enable/_write_enable single-cycle CPU strobes
//   io_address, io_write_data    register address / write data
//   io_read_data                 combinational read data (0 when no read)
//   tx_data, tx_valid, tx_ready  TX byte stream toward the UART
//   rx_data, rx_valid, rx_ready  RX byte stream from the UART
//   leds                         LED register
//   irq                          RX FIFO non-empty
//
// Handshake: a byte moves on a stream at the rising edge where valid and
// ready are both high. valid never depends combinationally on ready, and
// ready never depends combinationally on valid.
//
// Register map
//   0x0000 STATUS  RO  {4'b0, tx_count, rx_count, tx_drop, tx_empty, tx_full, rx_nonempty}
//   0x0001 TXDATA  WO  push io_write_data[7:0]; when full, drop the byte and set tx_drop
//   0x0002 RXDATA  RO  {8'h00, rx_head}, pops the entry; empty reads 0
//   0x0003 LEDS    RW
//   0x0004 CONTROL WO  b0 clears tx_drop, b1 flushes both FIFOs
module rcpu_io_responder #(
  parameter int FIFO_DEPTH = 8,
  parameter int LED_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic                 io_read_enable,
  input  logic                 io_write_enable,
  input  logic [15:0]          io_address,
  input  logic [15:0]          io_write_data,
  output logic [15:0]          io_read_data,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 irq
);

  localparam int         PW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

  logic [7:0]           tx_mem_q [FIFO_DEPTH];
  logic [7:0]           rx_mem_q [FIFO_DEPTH];
  logic [PW-1:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]        rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [3:0]           tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic                 tx_drop_q, tx_drop_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;

  logic wr_tx, wr_led, wr_ctl, rd_rx, flush;
  logic tx_full, tx_empty, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;

  // Full/empty always come from the registered (pre-edge) counts.
  assign tx_full  = (tx_cnt_q == DEPTH);
  assign tx_empty = (tx_cnt_q == 4'd0);
  assign rx_empty = (rx_cnt_q == 4'd0);

  assign wr_tx  = io_write_enable && (io_address == 16'h0001);
  assign wr_led = io_write_enable && (io_address == 16'h0003);
  assign wr_ctl = io_write_enable && (io_address == 16'h0004);
  assign rd_rx  = io_read_enable  && (io_address == 16'h0002);
  assign flush  = wr_ctl && io_write_data[1];

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem_q[tx_rd_q];
  assign rx_ready = (rx_cnt_q != DEPTH);
  assign irq      = !rx_empty;
  assign leds     = leds_q;

  assign tx_push = wr_tx && !tx_full;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = rd_rx && !rx_empty;

  always_comb begin
    tx_wr_d   = tx_wr_q;
    tx_rd_d   = tx_rd_q;
    tx_cnt_d  = tx_cnt_q;
    rx_wr_d   = rx_wr_q;
    rx_rd_d   = rx_rd_q;
    rx_cnt_d  = rx_cnt_q;
    tx_drop_d = tx_drop_q;
    leds_d    = leds_q;

    // A flush wins over any push/pop in the same cycle.
    if (flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = 4'd0;
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = 4'd0;
    end else begin
      if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 4'd1;
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 4'd1;

      if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 4'd1;
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 4'd1;
    end

    // Drop and clear come from different addresses, so they never coincide.
    if (wr_tx && tx_full)                 tx_drop_d = 1'b1;
    else if (wr_ctl && io_write_data[0])  tx_drop_d = 1'b0;

    if (wr_led) leds_d = io_write_data[LED_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= 4'd0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= 4'd0;
      tx_drop_q <= 1'b0;
      leds_q    <= '0;
      // Storage is cleared too so tx_data never shows stale bytes after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
    end else begin
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_drop_q <= tx_drop_d;
      leds_q    <= leds_d;
      if (tx_push && !flush) tx_mem_q[tx_wr_q] <= io_write_data[7:0];
      if (rx_push && !flush) rx_mem_q[rx_wr_q] <= rx_data;
    end
  end

  always_comb begin
    io_read_data = 16'h0000;
    if (io_read_enable) begin
      case (io_address)
        16'h0000: io_read_data = {4'h0, tx_cnt_q, rx_cnt_q, tx_drop_q,
                                  tx_empty, tx_full, !rx_empty};
        16'h0002: io_read_data = rx_empty ? 16'h0000 : {8'h00, rx_mem_q[rx_rd_q]};
        16'h0003: io_read_data = 16'(leds_q);
        default:  io_read_data = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_rcpu_io_responder.sv
module tb_rcpu_io_responder;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        io_read_enable = 1'b0;
  logic        io_write_enable = 1'b0;
  logic [15:0] io_address = 16'h0;
  logic [15:0] io_write_data = 16'h0;
  logic [15:0] io_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  leds;
  logic        irq;

  rcpu_io_responder #(.FIFO_DEPTH(DEPTH), .LED_WIDTH(8)) dut (
    .clk             (clk),
    .resetq          (resetq),
    .io_read_enable  (io_read_enable),
    .io_write_enable (io_write_enable),
    .io_address      (io_address),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .leds            (leds),
    .irq             (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_drop;
  logic [7:0] m_leds;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [10:0] exp_sig_q[$];   // {tx_valid, rx_ready, irq, leds}
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_status();
    int t, r;
    t = m_tx.size();
    r = m_rx.size();
    return 16'((r > 0 ? 1 : 0) + (t == DEPTH ? 2 : 0) + (t == 0 ? 4 : 0) +
               (m_drop ? 8 : 0) + r * 16 + t * 256);
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (resetq) begin
      if (exp_sig_q.size() > 0) begin
        logic [10:0] e;
        e = exp_sig_q.pop_front();
        chk("sig_tx_valid", 16'(tx_valid), 16'(e[10]));
        chk("sig_rx_ready", 16'(rx_ready), 16'(e[9]));
        chk("sig_irq",      16'(irq),      16'(e[8]));
        chk("sig_leds",     16'(leds),     16'(e[7:0]));
      end
      if (io_read_enable) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", io_read_data, 16'hxxxx);
        else chk("read_data", io_read_data, exp_rd_q.pop_front());
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx_q.size() == 0) chk("tx_unexpected", 16'(tx_data), 16'hxxxx);
        else chk("tx_byte", 16'(tx_data), 16'(exp_tx_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // One bus cycle: apply inputs, queue expectations from the model's pre-edge
  // view, cross the edge, then advance the model.
  task automatic do_cycle(input logic re, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic txr,
                          input logic rxv, input logic [7:0] rxd);
    bit tx_full, rx_full, flush;
    io_read_enable  = re;
    io_write_enable = we;
    io_address      = addr;
    io_write_data   = wdata;
    tx_ready        = txr;
    rx_valid        = rxv;
    rx_data         = rxd;

    exp_sig_q.push_back({m_tx.size() > 0, m_rx.size() != DEPTH, m_rx.size() > 0, m_leds});
    if (re) begin
      case (addr)
        16'h0000: exp_rd_q.push_back(model_status());
        16'h0002: exp_rd_q.push_back(m_rx.size() > 0 ? {8'h00, m_rx[0]} : 16'h0000);
        16'h0003: exp_rd_q.push_back({8'h00, m_leds});
        default:  exp_rd_q.push_back(16'h0000);
      endcase
    end
    if (txr && m_tx.size() > 0) exp_tx_q.push_back(m_tx[0]);

    @(posedge clk);
    #1;

    tx_full = (m_tx.size() == DEPTH);
    rx_full = (m_rx.size() == DEPTH);
    flush   = we && addr == 16'h0004 && wdata[1];
    if (we && addr == 16'h0001 && tx_full) m_drop = 1'b1;
    if (we && addr == 16'h0004 && wdata[0]) m_drop = 1'b0;
    if (we && addr == 16'h0003) m_leds = wdata[7:0];
    if (flush) begin
      m_tx.delete();
      m_rx.delete();
    end else begin
      if (txr && m_tx.size() > 0) void'(m_tx.pop_front());
      if (we && addr == 16'h0001 && !tx_full) m_tx.push_back(wdata[7:0]);
      if (re && addr == 16'h0002 && m_rx.size() > 0) void'(m_rx.pop_front());
      if (rxv && !rx_full) m_rx.push_back(rxd);
    end

    io_read_enable  = 1'b0;
    io_write_enable = 1'b0;
    tx_ready        = 1'b0;
    rx_valid        = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [15:0] data);
    do_cycle(1'b0, 1'b1, addr, data, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [15:0] addr);
    do_cycle(1'b1, 1'b0, addr, 16'h0000, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_drop = 1'b0;
    m_leds = 8'h00;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_valid", 16'(tx_valid), 16'h0);
    chk("reset_rx_ready", 16'(rx_ready), 16'h1);
    chk("reset_irq",      16'(irq),      16'h0);
    chk("reset_leds",     16'(leds),     16'h0);
    chk("reset_rdata",    io_read_data,  16'h0);
    resetq = 1'b1;
    @(posedge clk);
    #1;

    // 1: status after reset
    rd(16'h0000);

    // 2: single TX byte, held then drained
    wr(16'h0001, 16'h1234);
    chk("tx_data_head", 16'(tx_data), 16'h0034);
    rd(16'h0000);
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 8'h00);
    chk("tx_valid_drained", 16'(tx_valid), 16'h0);

    // 3: fill RX, then read it out plus one extra empty read
    for (int i = 0; i < DEPTH; i++)
      do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 8'(8'hA0 + i));
    chk("rx_ready_full", 16'(rx_ready), 16'h0);
    chk("irq_full",      16'(irq),      16'h1);
    rd(16'h0000);
    for (int i = 0; i < DEPTH + 1; i++) rd(16'h0002);
    chk("irq_empty", 16'(irq), 16'h0);

    // 4: overfill TX, check drop flag, clear it
    for (int i = 0; i < DEPTH + 1; i++) wr(16'h0001, 16'(16'h0050 + i));
    rd(16'h0000);
    wr(16'h0004, 16'h0001);
    rd(16'h0000);

    // 5: TX full, pop and write in the same cycle -> write dropped
    do_cycle(1'b0, 1'b1, 16'h0001, 16'h00EE, 1'b1, 1'b0, 8'h00);
    rd(16'h0000);
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 8'h00);

    // 6: LEDs, unmapped address, both strobes together
    wr(16'h0003, 16'h00FF);
    rd(16'h0003);
    rd(16'h0100);
    do_cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 8'h5A);
    do_cycle(1'b1, 1'b1, 16'h0002, 16'h0077, 1'b0, 1'b1, 8'h5B);
    wr(16'h0004, 16'h0002);   // flush
    rd(16'h0000);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a, d;
      int sel;
      sel = $urandom_range(0, 6);
      a = (sel == 5) ? 16'h0100 : (sel == 6) ? 16'h0005 : 16'(sel);
      d = 16'($urandom);
      if (a == 16'h0004) d = ($urandom_range(0, 7) == 0) ? 16'h0002 : 16'($urandom_range(0, 1));
      do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, d,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, 8'($urandom));
    end

    // Mid-stream reset: fill both FIFOs and LEDs, then pulse resetq
    wr(16'h0003, 16'h00C3);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 1'b1, 16'h0001, 16'(i), 1'b0, 1'b1, 8'(i));
    resetq = 1'b0;
    #1;
    chk("midrst_tx_valid", 16'(tx_valid), 16'h0);
    chk("midrst_rx_ready", 16'(rx_ready), 16'h1);
    chk("midrst_irq",      16'(irq),      16'h0);
    chk("midrst_leds",     16'(leds),     16'h0);
    #2;
    resetq = 1'b1;
    model_reset();
    rd(16'h0000);
    rd(16'h0002);

    @(posedge clk);
    #1;
    chk("rd_queue_drained",  16'(exp_rd_q.size()),  16'h0);
    chk("tx_queue_drained",  16'(exp_tx_q.size()),  16'h0);
    chk("sig_queue_drained", 16'(exp_sig_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
